// File: rtl/alu_cmd_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Imported by alu_cmd_seq and alu_rsp_mux.
package alu_cmd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        CAPT = 2'b10,
        RESP = 2'b11
    } state_t;

    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_CMP   = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    // Opcode bits [3:2] pick which ALU unit answers the command.
    function automatic logic [1:0] unit_sel(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_rsp_mux.sv
// Combinational result selector: picks one ALU unit's result and flag,
// zero-extending the narrow units to the full response width.
module alu_rsp_mux
    import alu_cmd_seq_pkg::*;
#(
    parameter int OP_WIDTH = 16
) (
    input  logic [1:0]            i_sel,
    input  logic [2*OP_WIDTH-1:0] i_arith,
    input  logic [OP_WIDTH-1:0]   i_logic,
    input  logic [OP_WIDTH-1:0]   i_cmp,
    input  logic [OP_WIDTH-1:0]   i_shift,
    input  logic                  i_arith_flag,
    input  logic                  i_logic_flag,
    input  logic                  i_cmp_flag,
    input  logic                  i_shift_flag,
    output logic [2*OP_WIDTH-1:0] o_data,
    output logic                  o_flag
);

    localparam logic [OP_WIDTH-1:0] ZERO_HI = '0;

    always_comb begin
        o_data = i_arith;
        o_flag = i_arith_flag;
        case (i_sel)
            SEL_ARITH: begin
                o_data = i_arith;
                o_flag = i_arith_flag;
            end
            SEL_LOGIC: begin
                o_data = {ZERO_HI, i_logic};
                o_flag = i_logic_flag;
            end
            SEL_CMP: begin
                o_data = {ZERO_HI, i_cmp};
                o_flag = i_cmp_flag;
            end
            SEL_SHIFT: begin
                o_data = {ZERO_HI, i_shift};
                o_flag = i_shift_flag;
            end
            default: begin
                o_data = i_arith;
                o_flag = i_arith_flag;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: accept a command, drive the ALU, capture the selected
// unit result and hold it for a response handshake. Optional macro: ALU_CMD_SEQ_STATS_EN.
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int OP_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [OP_WIDTH-1:0]   CMD_A,
    input  logic [OP_WIDTH-1:0]   CMD_B,
    input  logic [3:0]            CMD_FUN,
    output logic [OP_WIDTH-1:0]   ALU_A,
    output logic [OP_WIDTH-1:0]   ALU_B,
    output logic [3:0]            ALU_FUN,
    input  logic [2*OP_WIDTH-1:0] ARITH_IN,
    input  logic [OP_WIDTH-1:0]   LOGIC_IN,
    input  logic [OP_WIDTH-1:0]   CMP_IN,
    input  logic [OP_WIDTH-1:0]   SHIFT_IN,
    input  logic                  ARITH_FLAG_IN,
    input  logic                  LOGIC_FLAG_IN,
    input  logic                  CMP_FLAG_IN,
    input  logic                  SHIFT_FLAG_IN,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [2*OP_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_FLAG,
    output logic [3:0]            RSP_FUN,
    output logic                  BUSY
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [15:0]           OP_COUNT
`endif
);

    state_t                r_state;
    state_t                w_state_next;
    logic [OP_WIDTH-1:0]   r_alu_a;
    logic [OP_WIDTH-1:0]   r_alu_b;
    logic [3:0]            r_alu_fun;
    logic [3:0]            r_rsp_fun;
    logic [2*OP_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_flag;
    logic [2*OP_WIDTH-1:0] w_mux_data;
    logic                  w_mux_flag;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_rsp_hs;

    assign w_accept  = (r_state == IDLE) && CMD_VALID;
    assign w_capture = (r_state == CAPT);
    assign w_rsp_hs  = (r_state == RESP) && RSP_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (CMD_VALID) w_state_next = EXEC;
            EXEC:    w_state_next = CAPT;
            CAPT:    w_state_next = RESP;
            RESP:    if (RSP_READY) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operands are only reloaded on accept, so they stay put through EXEC and beyond.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_rsp_fun <= '0;
        end else if (w_accept) begin
            r_alu_a   <= CMD_A;
            r_alu_b   <= CMD_B;
            r_alu_fun <= CMD_FUN;
            r_rsp_fun <= CMD_FUN;
        end
    end

    alu_rsp_mux #(
        .OP_WIDTH (OP_WIDTH)
    ) u_rsp_mux (
        .i_sel        (unit_sel(r_alu_fun)),
        .i_arith      (ARITH_IN),
        .i_logic      (LOGIC_IN),
        .i_cmp        (CMP_IN),
        .i_shift      (SHIFT_IN),
        .i_arith_flag (ARITH_FLAG_IN),
        .i_logic_flag (LOGIC_FLAG_IN),
        .i_cmp_flag   (CMP_FLAG_IN),
        .i_shift_flag (SHIFT_FLAG_IN),
        .o_data       (w_mux_data),
        .o_flag       (w_mux_flag)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rsp_data <= '0;
            r_rsp_flag <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data <= w_mux_data;
            r_rsp_flag <= w_mux_flag;
        end
    end

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op_count <= '0;
        end else if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign OP_COUNT = r_op_count;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_rsp_hs;
`endif

    assign CMD_READY = (r_state == IDLE);
    assign BUSY      = (r_state != IDLE);
    assign RSP_VALID = (r_state == RESP);
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_FLAG  = r_rsp_flag;
    assign RSP_FUN   = r_rsp_fun;

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 16, the ALU operand width.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port CMD_VALID  input  1  command request.
REQ-005 SHALL have port CMD_READY  output  1  command accepted when high with CMD_VALID.
REQ-006 SHALL have ports CMD_A, CMD_B  input  OP_WIDTH  operands, and CMD_FUN  input  4  opcode.
REQ-007 SHALL have ports ALU_A, ALU_B  output  OP_WIDTH, and ALU_FUN  output  4, which drive the ALU.
REQ-008 SHALL have port ARITH_IN  input  2*OP_WIDTH, plus ports LOGIC_IN, CMP_IN, SHIFT_IN  input  OP_WIDTH  registered ALU unit results.
REQ-009 SHALL have ports ARITH_FLAG_IN, LOGIC_FLAG_IN, CMP_FLAG_IN, SHIFT_FLAG_IN  input  1  ALU unit flags.
REQ-010 SHALL have port RSP_VALID  output  1  and port RSP_READY  input  1, forming the response handshake.
REQ-011 SHALL have ports RSP_DATA  output  2*OP_WIDTH, RSP_FLAG  output  1, and RSP_FUN  output  4, which echoes the opcode.
REQ-012 SHALL have port BUSY  output  1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, EXEC, CAPT and RESP.
REQ-014 IDLE: CMD_READY=1; on CMD_VALID, latch CMD_A/B/FUN into ALU_A/B/FUN and RSP_FUN, then go to EXEC.
REQ-015 EXEC: one cycle, operands held stable so the ALU registers its result at the closing edge; then go to CAPT.
REQ-016 CAPT: one cycle; at its closing edge, sample the unit selected by ALU_FUN[3:2] and go to RESP.
REQ-017 Unit selection SHALL be: 00 = arith (full 2*OP_WIDTH), 01 = logic, 10 = cmp, 11 = shift; narrow results are zero-extended into RSP_DATA and RSP_FLAG takes the selected unit's flag.
REQ-018 RESP: RSP_VALID=1 with RSP_DATA, RSP_FLAG and RSP_FUN stable until RSP_READY=1; the handshake edge returns the FSM to IDLE.
REQ-019 Latency: a command accepted at edge N SHALL give RSP_VALID=1 from edge N+2; with no back-pressure the next command is accepted at edge N+4 at the earliest.
REQ-020 CMD_READY SHALL be 0 in every state except IDLE; CMD_VALID outside IDLE is ignored and no command is queued.
REQ-021 ALU_A/B/FUN SHALL hold their last value in all states after EXEC until the next accept.
REQ-022 RSP_READY held high while in IDLE, EXEC or CAPT SHALL have no effect.

Reset
REQ-023 RST=1 at a clock edge SHALL force IDLE and zero ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP_FLAG, RSP_FUN and RSP_VALID, and make BUSY=0 and CMD_READY=1 from the next cycle.
REQ-024 Reset mid-operation (EXEC, CAPT or RESP) SHALL discard the pending response; no RSP_VALID pulse follows.

Configuration
REQ-025 With ALU_CMD_SEQ_STATS_EN defined, the block SHALL add output OP_COUNT (16 bits), which increments on each response handshake, saturates at 16'hFFFF and clears on RST.
REQ-026 Without ALU_CMD_SEQ_STATS_EN, the OP_COUNT port and its counter SHALL NOT exist.

Structure
REQ-027 Package alu_cmd_seq_pkg SHALL hold the FSM state type and the unit-select constants (SEL_ARITH=2'b00, SEL_LOGIC=2'b01, SEL_CMP=2'b10, SEL_SHIFT=2'b11).
REQ-028 Result selection and zero-extension SHALL be one combinational sub-module, alu_rsp_mux; all other logic stays in alu_cmd_seq.

Verification
REQ-029 Arith: CMD A=16'h0005, B=16'h0003, FUN=4'b0000, accepted at edge N; ALU model ARITH_IN=32'h00000008 -> RSP_VALID at N+2, RSP_DATA=32'h00000008, RSP_FUN=4'b0000.
REQ-030 Logic zero-extension: FUN=4'b0100, LOGIC_IN=16'hFFFF, LOGIC_FLAG_IN=1 -> RSP_DATA=32'h0000FFFF, RSP_FLAG=1.
REQ-031 Back-pressure: RSP_READY=0 for 5 cycles in RESP while CMD_VALID=1 -> RSP fields stable, CMD_READY=0, no second accept; RSP_READY=1 -> IDLE, next command accepted one edge later.
REQ-032 Reset mid-op: RST=1 during CAPT -> next cycle BUSY=0, RSP_VALID=0, ALU_FUN=4'b0000, and RSP_VALID never rises for that command.
REQ-033 Stats (macro defined): preload near saturation, then 3 handshakes from OP_COUNT=16'hFFFE -> 16'hFFFF, holds at 16'hFFFF; RST -> 16'h0000.
